pc_fetch_gen: RTL and testbench
===============================

PC_FETCH_GEN -- requirements
Module: pc_fetch_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC width in bits.
REQ-002 SHALL have parameter IM_ADDR_W, default 14, instruction-memory word-address width.
REQ-003 SHALL have parameter RESET_VEC, default 0, PC value loaded at reset.
REQ-004 SHALL have parameter STEP, default 4, byte increment per sequential fetch (power of two, >= 4).
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port pc_write  input  1  1 = advance permitted, 0 = load-use stall.
REQ-008 SHALL have port redir_valid  input  1  branch/jump redirect request, single-cycle pulse.
REQ-009 SHALL have port redir_target  input  ADDR_W  redirect byte address.
REQ-010 SHALL have port trap_valid  input  1  trap request, single-cycle pulse.
REQ-011 SHALL have port trap_vec  input  ADDR_W  trap handler byte address.
REQ-012 SHALL have port im_ready  input  1  instruction memory accepts the current fetch.
REQ-013 SHALL have port im_req  output  1  fetch request valid.
REQ-014 SHALL have port im_addr  output  IM_ADDR_W  pc_out[IM_ADDR_W+1:2].
REQ-015 SHALL have port pc_out  output  ADDR_W  current fetch PC.
REQ-016 SHALL have port pc_seq  output  ADDR_W  pc_out + STEP, combinational, modulo 2^ADDR_W.
REQ-017 SHALL have port misalign  output  1  one-cycle pulse on an accepted target with low two bits nonzero.

Function
REQ-018 FSM states SHALL be BOOT, RUN, WAIT.
REQ-019 BOOT: im_req=0; next state RUN unconditionally; pc_out holds RESET_VEC.
REQ-020 RUN/WAIT: im_req=1; a fetch is accepted in a cycle where im_req=1 and im_ready=1.
REQ-021 RUN -> WAIT when im_ready=0; WAIT -> RUN when im_ready=1.
REQ-022 Next-PC priority SHALL be trap > pending > redir > stall > sequential.
REQ-023 On an accepted fetch: trap_valid loads trap_vec; else a pending redirect loads the pending target; else redir_valid loads redir_target; else pc_write=1 loads pc_seq; else pc_out holds.
REQ-024 Trap and redirect SHALL override pc_write=0 (the stall is not honoured on a control transfer).
REQ-025 redir_valid or trap_valid arriving while the fetch is not accepted (WAIT, or im_ready=0) SHALL be latched into a single pending register (trap wins when both arrive), and applied on the next accepted fetch.
REQ-026 A newer request arriving while a redirect is pending SHALL overwrite it; a trap SHALL never be overwritten by a redirect.
REQ-027 pc_out SHALL change only on an accepted fetch or reset; in WAIT, pc_out and im_addr SHALL remain stable.
REQ-028 Loaded targets SHALL have bits [1:0] forced to 0; misalign SHALL pulse for one cycle in the cycle after the load when the original bits [1:0] were nonzero.
REQ-029 Sequential increment SHALL wrap silently: pc_out = 2^ADDR_W - STEP advances to 0.
REQ-030 Redirect latency SHALL be one cycle: target is visible on pc_out the cycle after the accepting edge.

Reset
REQ-031 Asserted rst SHALL immediately force: state=BOOT, pc_out=RESET_VEC (bits [1:0] cleared), pending cleared, misalign=0, im_req=0.
REQ-032 Reset mid-WAIT or with a pending redirect SHALL discard the pending target; no fetch is issued until one cycle after deassertion.

Structure
REQ-033 The FSM state enum and the STEP/alignment constants SHALL live in the shared package alongside existing CPU defines.
REQ-034 Pending-redirect storage SHALL be a sub-module pc_redirect_buf (valid, is_trap, target).

Verification
REQ-035 Reset release with RESET_VEC=0x100 -> one cycle im_req=0, then im_req=1, pc_out 0x100, 0x104, 0x108 with im_ready=1.
REQ-036 pc_write=0 for 3 cycles at pc_out=0x20 -> pc_out holds 0x20 and im_addr holds 0x8; it resumes at 0x24.
REQ-037 redir_valid with target 0x400 while im_ready=0 for 2 cycles -> pc_out unchanged, then 0x400 after the first accepted edge.
REQ-038 trap_valid (0x80) and redir_valid (0x400) in the same accepted cycle with pc_write=0 -> pc_out=0x80.
REQ-039 Redirect to 0x203 -> pc_out=0x200 and misalign pulses for exactly one cycle.
REQ-040 pc_out=0xFFFF_FFFC, pc_write=1 -> pc_out=0x0, and rst asserted mid-WAIT with a pending trap -> pc_out=RESET_VEC and the trap is discarded.

Source files
------------

// File: rtl/pc_fetch_gen_pkg.sv
// pc_fetch_gen_pkg: shared CPU defines plus the fetch-stage FSM state and alignment constants
package pc_fetch_gen_pkg;
    localparam int XLEN         = 32;
    localparam int IMEM_WORD_AW = 14;
    localparam int FETCH_STEP   = 4;
    localparam int ALIGN_BITS   = 2;
    typedef enum logic [1:0] {BOOT, RUN, WAIT} fetch_state_t;
endpackage

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: single-entry store for a control transfer that arrived while no fetch was accepted
module pc_redirect_buf
    import pc_fetch_gen_pkg::*;
#(
    parameter int ADDR_W = XLEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic              clear,
    input  logic              req_trap,
    input  logic [ADDR_W-1:0] req_target,
    output logic              valid,
    output logic              is_trap,
    output logic [ADDR_W-1:0] target
);
    // clear wins over capture; the caller decides whether a new request may overwrite the held one
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            valid   <= 1'b0;
            is_trap <= 1'b0;
            target  <= '0;
        end else if (clear) begin
            valid   <= 1'b0;
            is_trap <= 1'b0;
        end else if (capture) begin
            valid   <= 1'b1;
            is_trap <= req_trap;
            target  <= req_target;
        end
endmodule

// File: rtl/pc_fetch_gen.sv
// pc_fetch_gen: program counter and instruction-fetch request generator with trap/redirect handling
module pc_fetch_gen
    import pc_fetch_gen_pkg::*;
#(
    parameter int              ADDR_W    = XLEN,
    parameter int              IM_ADDR_W = IMEM_WORD_AW,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int              STEP      = FETCH_STEP
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pc_write,
    input  logic                 redir_valid,
    input  logic [ADDR_W-1:0]    redir_target,
    input  logic                 trap_valid,
    input  logic [ADDR_W-1:0]    trap_vec,
    input  logic                 im_ready,
    output logic                 im_req,
    output logic [IM_ADDR_W-1:0] im_addr,
    output logic [ADDR_W-1:0]    pc_out,
    output logic [ADDR_W-1:0]    pc_seq,
    output logic                 misalign
);
    function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:ALIGN_BITS], ALIGN_BITS'(0)};
    endfunction

    fetch_state_t      state, state_next;
    logic              accept, load, mis_next, capture;
    logic              pend_valid, pend_trap;
    logic [ADDR_W-1:0] pend_target, tgt, cap_target, pc_next;

    assign pc_seq  = pc_out + ADDR_W'(STEP);
    assign im_addr = pc_out[IM_ADDR_W+ALIGN_BITS-1:ALIGN_BITS];

    pc_redirect_buf #(.ADDR_W(ADDR_W)) u_buf (
        .clk        (clk),
        .rst        (rst),
        .capture    (capture),
        .clear      (accept),
        .req_trap   (trap_valid),
        .req_target (cap_target),
        .valid      (pend_valid),
        .is_trap    (pend_trap),
        .target     (pend_target)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= BOOT;
        else      state <= state_next;

    // next state, fetch acceptance, next-PC priority and pending-capture decision
    always_comb begin
        im_req     = state != BOOT;
        accept     = im_req && im_ready;
        state_next = (state == BOOT || im_ready) ? RUN : WAIT;
        load       = trap_valid || pend_valid || redir_valid;
        tgt        = trap_valid ? trap_vec : pend_valid ? pend_target : redir_target;
        pc_next    = !accept ? pc_out : load ? align(tgt) : pc_write ? pc_seq : pc_out;
        mis_next   = accept && load && (|tgt[ALIGN_BITS-1:0]);
        capture    = !accept && (trap_valid || (redir_valid && !(pend_valid && pend_trap)));
        cap_target = trap_valid ? trap_vec : redir_target;
    end

    // PC and misalign pulse registers
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            pc_out   <= align(RESET_VEC);
            misalign <= 1'b0;
        end else begin
            pc_out   <= pc_next;
            misalign <= mis_next;
        end
endmodule

// File: tb/tb_pc_fetch_gen.sv
// tb_pc_fetch_gen: directed bench with a cycle model and literal checkpoints for pc_fetch_gen
module tb_pc_fetch_gen;
    localparam logic [31:0] RV = 32'h100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pc_write = 1'b1;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_target = '0;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_vec = '0;
    logic        im_ready = 1'b1;
    logic        im_req;
    logic [13:0] im_addr;
    logic [31:0] pc_out, pc_seq;
    logic        misalign;

    int n_pass = 0;
    int n_total = 0;

    pc_fetch_gen #(.ADDR_W(32), .IM_ADDR_W(14), .RESET_VEC(RV), .STEP(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_write     (pc_write),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .trap_valid   (trap_valid),
        .trap_vec     (trap_vec),
        .im_ready     (im_ready),
        .im_req       (im_req),
        .im_addr      (im_addr),
        .pc_out       (pc_out),
        .pc_seq       (pc_seq),
        .misalign     (misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Model: "live" means at least one clock edge has passed since reset;
    // a fetch is taken when live and memory is ready, otherwise requests are parked.
    logic        m_live = 1'b0;
    logic [31:0] m_pc = RV;
    logic        m_mis = 1'b0;
    logic        m_has = 1'b0;
    logic        m_has_trap = 1'b0;
    logic [31:0] m_held = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_live <= 1'b0;
            m_pc   <= RV & ~32'h3;
            m_mis  <= 1'b0;
            m_has  <= 1'b0;
            m_has_trap <= 1'b0;
        end else begin
            m_live <= 1'b1;
            if (m_live && im_ready) begin
                m_has <= 1'b0;
                m_has_trap <= 1'b0;
                if (trap_valid) begin
                    m_pc <= trap_vec & ~32'h3; m_mis <= (trap_vec % 4) != 0;
                end else if (m_has) begin
                    m_pc <= m_held & ~32'h3; m_mis <= (m_held % 4) != 0;
                end else if (redir_valid) begin
                    m_pc <= redir_target & ~32'h3; m_mis <= (redir_target % 4) != 0;
                end else begin
                    m_pc <= pc_write ? m_pc + 32'd4 : m_pc; m_mis <= 1'b0;
                end
            end else begin
                m_mis <= 1'b0;
                if (trap_valid) begin
                    m_has <= 1'b1; m_has_trap <= 1'b1; m_held <= trap_vec;
                end else if (redir_valid && !m_has_trap) begin
                    m_has <= 1'b1; m_held <= redir_target;
                end
            end
        end
    end

    // every-cycle comparison against the model, away from the rising edge
    always @(negedge clk) begin
        chk("m_im_req", 32'(im_req), 32'(m_live));
        chk("m_pc_out", pc_out, m_pc);
        chk("m_pc_seq", pc_seq, m_pc + 32'd4);
        chk("m_im_addr", 32'(im_addr), (m_pc / 4) % 32'h4000);
        chk("m_misalign", 32'(misalign), 32'(m_mis));
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) tick;
        chk("rst_pc", pc_out, 32'h100);
        chk("rst_req", 32'(im_req), 32'h0);
        rst = 1'b1;
        #1 chk("boot_req", 32'(im_req), 32'h0);
        tick; chk("run_req", 32'(im_req), 32'h1); chk("seq0", pc_out, 32'h100); chk("seq0_addr", 32'(im_addr), 32'h40);
        tick; chk("seq1", pc_out, 32'h104);
        tick; chk("seq2", pc_out, 32'h108);
        redir_valid = 1'b1; redir_target = 32'h20;
        tick; redir_valid = 1'b0; chk("redir20", pc_out, 32'h20);
        pc_write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick; chk("stall_pc", pc_out, 32'h20); chk("stall_addr", 32'(im_addr), 32'h8);
        end
        pc_write = 1'b1;
        tick; chk("resume", pc_out, 32'h24);
        im_ready = 1'b0; redir_valid = 1'b1; redir_target = 32'h400;
        tick; redir_valid = 1'b0; chk("wait_pc0", pc_out, 32'h24);
        tick; chk("wait_pc1", pc_out, 32'h24);
        im_ready = 1'b1;
        tick; chk("pend_redir", pc_out, 32'h400);
        tick; chk("after_pend", pc_out, 32'h404);
        trap_valid = 1'b1; trap_vec = 32'h80; redir_valid = 1'b1; redir_target = 32'h400; pc_write = 1'b0;
        tick; trap_valid = 1'b0; redir_valid = 1'b0; pc_write = 1'b1; chk("trap_prio", pc_out, 32'h80);
        redir_valid = 1'b1; redir_target = 32'h203;
        tick; redir_valid = 1'b0; chk("mis_pc", pc_out, 32'h200); chk("mis_on", 32'(misalign), 32'h1);
        tick; chk("mis_off", 32'(misalign), 32'h0); chk("mis_next", pc_out, 32'h204);
        im_ready = 1'b0; trap_valid = 1'b1; trap_vec = 32'h80;
        tick; trap_valid = 1'b0; redir_valid = 1'b1; redir_target = 32'h600;
        tick; redir_valid = 1'b0; im_ready = 1'b1;
        tick; chk("trap_kept", pc_out, 32'h80);
        redir_valid = 1'b1; redir_target = 32'hFFFF_FFFC;
        tick; redir_valid = 1'b0; chk("top_pc", pc_out, 32'hFFFF_FFFC); chk("top_seq", pc_seq, 32'h0);
        tick; chk("wrap", pc_out, 32'h0);
        im_ready = 1'b0;
        tick; trap_valid = 1'b1; trap_vec = 32'h3000;
        tick; trap_valid = 1'b0; chk("wait_hold", pc_out, 32'h0);
        rst = 1'b0;
        #1 chk("async_pc", pc_out, 32'h100); chk("async_req", 32'(im_req), 32'h0);
        tick; rst = 1'b1; im_ready = 1'b1;
        tick; chk("rel_pc", pc_out, 32'h100); chk("rel_req", 32'(im_req), 32'h1);
        tick; chk("trap_gone", pc_out, 32'h104);
        tick;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
